// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the countdown timer
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int ONE           = 1;

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with done pulse and optional auto-reload
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(ONE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // abort in the handshake cycle suppresses the load
        if (load_valid && !abort) begin
          value_d  = load_value;
          reload_d = load_value;
          if (load_value == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          value_d = '0;
        end else if (enable) begin
          if (value_q == TERMINAL) begin
            done_d = 1'b1;
            if (auto_reload) begin
              value_d = reload_q;
            end else begin
              value_d = '0;
              state_d = IDLE;
            end
          end else if (value_q != '0) begin
            value_d = value_q - TERMINAL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      value_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign value      = value_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);
  assign load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed checks of countdown_timer against a step-count model
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_value = '0;
  logic       enable = 1'b0;
  logic       auto_reload = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] value;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model: a run is "N loaded, k enabled steps taken"; value is N-k while running, 0 otherwise
  bit m_run = 1'b0;
  int m_n = 0;
  int m_steps = 0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .enable(enable),
    .auto_reload(auto_reload),
    .abort(abort),
    .value(value),
    .busy(busy),
    .done(done)
  );

  function automatic int exp_value();
    return m_run ? (m_n - m_steps) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit d;
    d = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_n = 0; m_steps = 0;
    end else if (!m_run) begin
      if (load_valid && !abort) begin
        if (load_value == 0) d = 1'b1;
        else begin
          m_run = 1'b1; m_n = int'(load_value); m_steps = 0;
        end
      end
    end else if (abort) begin
      m_run = 1'b0;
    end else if (enable) begin
      m_steps++;
      if (m_steps == m_n) begin
        d = 1'b1;
        if (auto_reload) m_steps = 0;
        else m_run = 1'b0;
      end
    end
    m_done = d;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("value", int'(value), exp_value());
      chk("done", int'(done), int'(m_done));
      chk("busy", int'(busy), int'(m_run));
      chk("load_ready", int'(load_ready), int'(!m_run));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // hand-computed expectation checked against both DUT and model
  task automatic lit(input string name, input int v, input int d, input int b);
    chk({name, "_value"}, int'(value), v);
    chk({name, "_done"}, int'(done), d);
    chk({name, "_busy"}, int'(busy), b);
    chk({name, "_model"}, exp_value(), v);
  endtask

  task automatic load(input int n);
    load_valid = 1'b1;
    load_value = 8'(n);
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    int en_seq[6];
    int pv[6];
    en_seq = '{1, 0, 0, 1, 1, 1};
    pv = '{3, 3, 3, 2, 1, 0};

    // reset with a load presented: nothing taken
    rst = 1'b1; load_valid = 1'b1; load_value = 8'd5;
    tick(); tick();
    chk_en = 1'b1;
    lit("reset", 0, 0, 0);
    chk("reset_ready", int'(load_ready), 1);
    rst = 1'b0; load_valid = 1'b0;

    // one-shot 5
    enable = 1'b1; auto_reload = 1'b0;
    load(5);
    lit("os_load", 5, 0, 1);
    for (int i = 4; i >= 1; i--) begin
      tick();
      lit("os_step", i, 0, 1);
    end
    tick();
    lit("os_term", 0, 1, 0);
    chk("os_ready", int'(load_ready), 1);
    tick();
    lit("os_after", 0, 0, 0);

    // pause
    load(4);
    lit("pause_load", 4, 0, 1);
    for (int i = 0; i < 6; i++) begin
      enable = en_seq[i][0];
      tick();
      lit("pause_step", pv[i], (i == 5) ? 1 : 0, (i == 5) ? 0 : 1);
    end

    // auto-reload period 3
    enable = 1'b1; auto_reload = 1'b1;
    load(3);
    lit("ar_load", 3, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      lit("ar_step", (i % 3 == 2) ? 3 : 2 - (i % 3), (i % 3 == 2) ? 1 : 0, 1);
    end
    abort = 1'b1;
    tick();
    lit("ar_abort", 0, 0, 0);
    abort = 1'b0; auto_reload = 1'b0;

    // zero-length load
    load(0);
    lit("zero", 0, 1, 0);
    tick();
    lit("zero_after", 0, 0, 0);

    // full-scale load, no wrap
    load(255);
    lit("max_load", 255, 0, 1);
    for (int i = 1; i < 255; i++) tick();
    lit("max_pre", 1, 0, 1);
    tick();
    lit("max_term", 0, 1, 0);
    tick();

    // abort on terminal cycle
    load(2);
    tick();
    lit("abt_pre", 1, 0, 1);
    abort = 1'b1;
    tick();
    lit("abt_term", 0, 0, 0);
    abort = 1'b0;

    // reset mid-run
    load(10);
    tick(); tick(); tick();
    lit("rst_mid_pre", 7, 0, 1);
    rst = 1'b1;
    tick();
    lit("rst_mid", 0, 0, 0);
    rst = 1'b0;

    // load_valid in RUN is ignored
    load(6);
    load_valid = 1'b1; load_value = 8'd99;
    tick(); tick(); tick();
    lit("ign", 3, 0, 1);
    load_valid = 1'b0;

    // abort during handshake wins
    abort = 1'b1;
    tick();
    load_valid = 1'b1; load_value = 8'd7;
    tick();
    lit("abt_hs", 0, 0, 0);
    load_valid = 1'b0; abort = 1'b0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      load_valid  = ($urandom_range(0, 3) == 0);
      load_value  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      enable      = ($urandom_range(0, 3) != 0);
      auto_reload = ($urandom_range(0, 1) == 1);
      abort       = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0; load_valid = 1'b0; abort = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
